mini_mips_core: RTL and testbench

- Single-cycle 16-bit-instruction mini-MIPS execution core with a 32-bit datapath.
- Contains an 8 x 32-bit register file, an ALU and a word-addressed data memory.
- Executes one instruction per clock when `valid` is high.
- `result` presents the value produced by the last executed instruction.

---
 rtl/minimips_pkg.sv | 34 +++
 rtl/minimips_alu.sv | 26 ++
 rtl/mini_mips_core.sv | 121 ++++++++++++
 tb/tb_mini_mips_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minimips_pkg.sv
// Shared constants and types for the mini-MIPS core: opcodes, R-type function codes,
// ALU operation encoding and register index width.
package minimips_pkg;

    localparam int REG_IDX_W = 3;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_NORI  = 4'b0100;
    localparam logic [3:0] OP_SLTI  = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_ADD = 3'b001;
    localparam logic [2:0] F_SUB = 3'b010;
    localparam logic [2:0] F_XOR = 3'b011;
    localparam logic [2:0] F_NOR = 3'b100;
    localparam logic [2:0] F_OR  = 3'b101;
    localparam logic [2:0] F_SLT = 3'b110;

    typedef enum logic [2:0] {
        ALU_AND,
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_NOR,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

endpackage

// File: rtl/minimips_alu.sv
// Combinational 32-bit ALU for the mini-MIPS core; SLT is a signed compare
// producing 1 or 0.
module minimips_alu
    import minimips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_AND: y_o = a_i & b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_NOR: y_o = ~(a_i | b_i);
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mini_mips_core.sv
// Single-cycle mini-MIPS core: 8x32 register file, ALU and word-addressed data memory.
// Optional build macro MINIMIPS_ZERO_REG_EN makes register 0 a hard-wired zero.
module mini_mips_core
    import minimips_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] instruction,
    output logic [31:0] result
);

    localparam int AW = $clog2(MEM_DEPTH);

    // valid qualifies instruction for the next rising edge; there is no backpressure,
    // so every edge with valid high executes exactly one instruction.

    logic [31:0] regs_q [8];
    logic [31:0] mem_q  [MEM_DEPTH];
    logic [31:0] result_q, result_d;

    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] rs, rt, rd;
    logic [2:0]           func;
    logic [31:0]          imm_s, imm_z;

    assign opcode = instruction[15:12];
    assign rs     = instruction[11:9];
    assign rt     = instruction[8:6];
    assign rd     = instruction[5:3];
    assign func   = instruction[2:0];
    assign imm_s  = {{26{instruction[5]}}, instruction[5:0]};
    assign imm_z  = {26'd0, instruction[5:0]};

    logic [31:0] rs_val, rt_val;
    logic        reg_we, reg_wr_en, mem_we, is_lw;
    logic [REG_IDX_W-1:0] dst;

`ifdef MINIMIPS_ZERO_REG_EN
    assign rs_val    = (rs == '0) ? '0 : regs_q[rs];
    assign rt_val    = (rt == '0) ? '0 : regs_q[rt];
    assign reg_wr_en = reg_we && (dst != '0);
`else
    assign rs_val    = regs_q[rs];
    assign rt_val    = regs_q[rt];
    assign reg_wr_en = reg_we;
`endif

    // Address wraps modulo MEM_DEPTH, so only the low AW bits of the sum matter.
    logic [AW-1:0] addr;
    logic [31:0]   mem_rd;
    assign addr   = rs_val[AW-1:0] + imm_s[AW-1:0];
    assign mem_rd = mem_q[addr];

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_y;

    minimips_alu u_alu (
        .a_i  (rs_val),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rt_val;
        reg_we = 1'b0;
        mem_we = 1'b0;
        is_lw  = 1'b0;
        dst    = rt;
        case (opcode)
            OP_RTYPE: begin
                dst    = rd;
                reg_we = (func != 3'b111);
                case (func)
                    F_AND:   alu_op = ALU_AND;
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_XOR:   alu_op = ALU_XOR;
                    F_NOR:   alu_op = ALU_NOR;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; alu_b = imm_s; reg_we = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_z; reg_we = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_z; reg_we = 1'b1; end
            OP_NORI: begin alu_op = ALU_NOR; alu_b = imm_z; reg_we = 1'b1; end
            OP_SLTI: begin alu_op = ALU_SLT; alu_b = imm_s; reg_we = 1'b1; end
            OP_LW:   begin reg_we = 1'b1; is_lw = 1'b1; end
            OP_SW:   mem_we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        result_d = '0;
        if (is_lw)       result_d = mem_rd;
        else if (mem_we) result_d = rt_val;
        else if (reg_we) result_d = alu_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            for (int j = 0; j < int'(MEM_DEPTH); j++) mem_q[j] <= '0;
            result_q <= '0;
        end else if (valid) begin
            if (reg_wr_en) regs_q[dst] <= result_d;
            if (mem_we)    mem_q[addr] <= rt_val;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mini_mips_core.sv
// Bench for mini_mips_core: directed vector table, hand-written corner sequences
// and randomized instructions checked against a behavioural model.
module tb_mini_mips_core;

    localparam int MEM_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [15:0] instruction;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mini_mips_core #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .instruction (instruction),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ins;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    logic [31:0] m_regs [8];
    logic [31:0] m_mem  [MEM_DEPTH];
    logic [31:0] m_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] i, input logic [31:0] e);
        vec_t v;
        v.ins = i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [15:0] ins, input logic v);
        instruction = ins;
        valid       = v;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = '0;
        m_res = '0;
    endtask

    function automatic logic [31:0] m_rd(input int idx);
`ifdef MINIMIPS_ZERO_REG_EN
        if (idx == 0) return 32'd0;
`endif
        return m_regs[idx];
    endfunction

    task automatic m_wr(input int idx, input logic [31:0] val);
`ifdef MINIMIPS_ZERO_REG_EN
        if (idx == 0) return;
`endif
        m_regs[idx] = val;
    endtask

    // Reference model: executes one instruction on the model state, returns the expected result.
    task automatic model_step(input logic [15:0] ins, input logic v, output logic [31:0] exp);
        logic [31:0] a, b, se, ze, r;
        int op, fn, dst, addr;
        bit wr;
        if (!v) begin
            exp = m_res;
        end else begin
            op  = int'(ins[15:12]);
            fn  = int'(ins[2:0]);
            se  = {{26{ins[5]}}, ins[5:0]};
            ze  = {26'd0, ins[5:0]};
            a   = m_rd(int'(ins[11:9]));
            b   = m_rd(int'(ins[8:6]));
            dst = int'(ins[8:6]);
            addr = int'((a + se) % MEM_DEPTH);
            r  = 32'd0;
            wr = 1'b0;
            case (op)
                0: begin
                    dst = int'(ins[5:3]);
                    wr  = 1'b1;
                    case (fn)
                        0: r = a & b;
                        1: r = a + b;
                        2: r = a - b;
                        3: r = a ^ b;
                        4: r = ~(a | b);
                        5: r = a | b;
                        6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end
                1: begin r = a + se; wr = 1'b1; end
                2: begin r = a & ze; wr = 1'b1; end
                3: begin r = a | ze; wr = 1'b1; end
                4: begin r = ~(a | ze); wr = 1'b1; end
                5: begin r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = 1'b1; end
                8: begin r = m_mem[addr]; wr = 1'b1; end
                9: begin m_mem[addr] = b; r = b; end
                default: r = 32'd0;
            endcase
            if (wr) m_wr(dst, r);
            m_res = r;
            exp   = r;
        end
    endtask

    initial begin
        logic [3:0]  ops [12];
        logic [11:0] low;
        logic [15:0] ins;
        logic [31:0] e;
        logic        v;
        logic [31:0] r0_exp;

        reset       = 1'b1;
        valid       = 1'b0;
        instruction = '0;
        #12;
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        add_vec(16'b0001_000_001_111110, 32'hFFFF_FFFE); // ADDI r1 = -2
        add_vec(16'b0011_000_010_101010, 32'h0000_002A); // ORI  r2 = 0x2A
        add_vec(16'b0000_001_010_011_001, 32'h0000_0028); // ADD  r3
        add_vec(16'b0000_001_010_100_010, 32'hFFFF_FFD4); // SUB  r4
        add_vec(16'b0000_001_010_101_110, 32'h0000_0001); // SLT  r5
        add_vec(16'b0101_010_110_111111, 32'h0000_0000); // SLTI r6
        add_vec(16'b1001_000_011_010110, 32'h0000_0028); // SW   mem[22]
        add_vec(16'b1000_000_111_010110, 32'h0000_0028); // LW   r7
        add_vec(16'b0000_011_001_101_000, 32'h0000_0028); // AND
        add_vec(16'b0000_001_010_101_011, 32'hFFFF_FFD4); // XOR
        add_vec(16'b0000_001_010_101_100, 32'h0000_0001); // NOR
        add_vec(16'b0000_011_010_101_101, 32'h0000_002A); // OR   r5 = 0x2A
        add_vec(16'b0000_001_010_101_111, 32'h0000_0000); // reserved func
        add_vec(16'b0011_101_101_000000, 32'h0000_002A); // read r5 unchanged
        add_vec(16'b0010_001_101_110011, 32'h0000_0032); // ANDI zext
        add_vec(16'b0100_010_101_000001, 32'hFFFF_FFD4); // NORI
        add_vec(16'b0110_101_101_000000, 32'h0000_0000); // unused opcode
        add_vec(16'b0011_101_101_000000, 32'hFFFF_FFD4); // read r5 unchanged
        add_vec(16'b0101_001_101_000000, 32'h0000_0001); // SLTI -2 < 0
        add_vec(16'b1001_001_011_000001, 32'h0000_0028); // SW   wraps to 63
        add_vec(16'b1000_000_110_111111, 32'h0000_0028); // LW   0-1 wraps to 63
        add_vec(16'b1000_001_110_000001, 32'h0000_0028); // LW   -2+1 wraps to 63
        add_vec(16'b1000_000_110_000001, 32'h0000_0000); // LW   mem[1] untouched
        add_vec(16'b0001_001_001_000001, 32'hFFFF_FFFF); // ADDI r1 += 1 (dest = src)
        add_vec(16'b0000_111_111_111_001, 32'h0000_0050); // ADD  r7 = r7 + r7
        add_vec(16'b0011_111_111_000000, 32'h0000_0050); // read r7
        add_vec(16'b1111_000_001_000000, 32'h0000_0000); // unused opcode
        add_vec(16'b0001_000_010_011111, 32'h0000_001F); // ADDI max positive imm

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ins, 1'b1);
            check($sformatf("vec%0d", i), result, vecs[i].exp);
        end

        // valid low: instruction ignored, result holds
        step(16'b0001_010_010_000111, 1'b0);
        check("hold_result", result, 32'h0000_001F);
        step(16'b0011_010_010_000000, 1'b1);
        check("hold_r2", result, 32'h0000_001F);

        // asynchronous reset between edges, held over an edge with valid high
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", result, 32'd0);
        instruction = 16'b0001_000_011_000101;
        valid       = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        step(16'b1000_000_111_010110, 1'b1);
        check("post_reset_mem22", result, 32'd0);
        step(16'b0011_011_011_000000, 1'b1);
        check("post_reset_r3", result, 32'd0);
        step(16'b0011_001_001_000000, 1'b1);
        check("post_reset_r1", result, 32'd0);

        // register 0 behaviour
        step(16'b0001_000_000_000101, 1'b1);
        check("r0_write_result", result, 32'd5);
`ifdef MINIMIPS_ZERO_REG_EN
        r0_exp = 32'd0;
`else
        r0_exp = 32'd5;
`endif
        step(16'b0011_000_000_000000, 1'b1);
        check("r0_read", result, r0_exp);

        // randomized instructions against the model
        ops = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd14};
        do_reset();
        for (int n = 0; n < 500; n++) begin
            low = 12'($urandom_range(0, 4095));
            ins = {ops[$urandom_range(0, 11)], low};
            v   = ($urandom_range(0, 7) != 0);
            model_step(ins, v, e);
            exp_q.push_back(e);
            step(ins, v);
            e = exp_q.pop_front();
            check($sformatf("rand%0d ins=%h", n, ins), result, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
